// File: rtl/leaf_out_sched_pkg.sv
// Shared packet layout, control opcodes and helpers for the leaf output scheduler.
package leaf_pkg;

    localparam int PACKET_BITS   = 49;
    localparam int PAYLOAD_BITS  = 32;
    localparam int NUM_LEAF_BITS = 5;
    localparam int NUM_PORT_BITS = 4;
    localparam int NUM_ADDR_BITS = 7;

    // Field positions inside a BFT packet: {valid, leaf, port, addr, payload}
    localparam int VALID_BIT = 48;
    localparam int LEAF_LSB  = 43;
    localparam int PORT_LSB  = 39;
    localparam int ADDR_LSB  = 32;

    // Control packets arrive addressed to port 0 of this leaf
    localparam logic [NUM_PORT_BITS-1:0] CTRL_PORT = '0;

    // Control opcode lives in addr[6:5]; the target port index in addr[3:0]
    typedef enum logic [1:0] {
        OP_NOP    = 2'b00,
        OP_CFG    = 2'b01,
        OP_CREDIT = 2'b10,
        OP_RSVD   = 2'b11
    } ctrl_op_e;

    typedef struct packed {
        logic                     valid;
        logic [NUM_LEAF_BITS-1:0] leaf;
        logic [NUM_PORT_BITS-1:0] port;
        logic [NUM_ADDR_BITS-1:0] addr;
        logic [PAYLOAD_BITS-1:0]  payload;
    } packet_t;

    function automatic logic is_ctrl(input logic [PACKET_BITS-1:0] pkt);
        return pkt[VALID_BIT] && (pkt[PORT_LSB +: NUM_PORT_BITS] == CTRL_PORT);
    endfunction

endpackage

// File: rtl/leaf_out_sched_if.sv
// BFT link and user-stream signals of the leaf output scheduler.
// slave: the scheduler itself; master: the BFT/user side driving it.
interface leaf_out_sched_if
    import leaf_pkg::*;
#(
    parameter int NUM_OUT_PORTS = 4
) ();

    logic [PACKET_BITS-1:0]                din_leaf_bft2interface;
    logic [PACKET_BITS-1:0]                dout_leaf_interface2bft;
    logic                                  resend;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] din_leaf_user2interface;
    logic [NUM_OUT_PORTS-1:0]              vld_user2interface;
    logic [NUM_OUT_PORTS-1:0]              ack_interface2user;

    modport slave (
        input  din_leaf_bft2interface,
        input  resend,
        input  din_leaf_user2interface,
        input  vld_user2interface,
        output dout_leaf_interface2bft,
        output ack_interface2user
    );

    modport master (
        output din_leaf_bft2interface,
        output resend,
        output din_leaf_user2interface,
        output vld_user2interface,
        input  dout_leaf_interface2bft,
        input  ack_interface2user
    );

endinterface

// File: rtl/leaf_out_sched_rr_arbiter.sv
// N-way round-robin arbiter. Search starts at the pointer and wraps; the
// pointer moves to one past the winner whenever advance is asserted.
module rr_arbiter
    import leaf_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             found;

    // Pick the first requester at or above the pointer, wrapping past N-1
    always_comb begin
        logic [IDX_W:0]   sum;
        logic [IDX_W-1:0] cand;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        sum     = '0;
        cand    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (sum >= (IDX_W+1)'(N)) begin
                sum = sum - (IDX_W+1)'(N);
            end
            cand = sum[IDX_W-1:0];
            if (!found && req_i[cand]) begin
                found         = 1'b1;
                grant_o[cand] = 1'b1;
                idx_o         = cand;
            end
        end
    end

    // Pointer follows the winner; holds when nothing is granted
    always_comb begin
        ptr_d = ptr_q;
        if (advance_i && found) begin
            if (idx_o == IDX_W'(N-1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_o + IDX_W'(1);
            end
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/leaf_out_sched.sv
// Leaf output scheduler: shares the single BFT output link among the user
// output streams. Destinations and credits are programmed by control packets
// arriving on the BFT input; grants are round-robin among eligible ports.
module leaf_out_sched
    import leaf_pkg::*;
#(
    parameter int NUM_OUT_PORTS         = 4,
    parameter int CREDIT_BITS           = 9,
    parameter int FREESPACE_UPDATE_SIZE = 64
) (
    input  logic             clk,
    input  logic             reset,
    leaf_out_sched_if.slave  bus
);

    localparam int IDX_W = (NUM_OUT_PORTS > 1) ? $clog2(NUM_OUT_PORTS) : 1;
    localparam logic [CREDIT_BITS-1:0] CREDIT_MAX  = '1;
    localparam logic [CREDIT_BITS-1:0] CREDIT_INIT = CREDIT_BITS'(FREESPACE_UPDATE_SIZE);

    logic [NUM_LEAF_BITS-1:0] dest_leaf_q [NUM_OUT_PORTS];
    logic [NUM_LEAF_BITS-1:0] dest_leaf_d [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dest_port_q [NUM_OUT_PORTS];
    logic [NUM_PORT_BITS-1:0] dest_port_d [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_q    [NUM_OUT_PORTS];
    logic [CREDIT_BITS-1:0]   credit_d    [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_q       [NUM_OUT_PORTS];
    logic [NUM_ADDR_BITS-1:0] seq_d       [NUM_OUT_PORTS];
    logic [NUM_OUT_PORTS-1:0] cfg_valid_q, cfg_valid_d;
    packet_t                  dout_q, dout_d;
    packet_t                  last_q, last_d;

    logic                     ctrl_hit;
    ctrl_op_e                 ctrl_op;
    logic [3:0]               ctrl_sel;
    logic [CREDIT_BITS-1:0]   credit_add;
    logic [NUM_OUT_PORTS-1:0] cfg_wr, credit_wr;
    logic [NUM_OUT_PORTS-1:0] eligible, grant;
    logic [IDX_W-1:0]         gnt_idx;
    logic                     any_grant;
    logic [PAYLOAD_BITS-1:0]  pkt_data;
    packet_t                  out_pkt;

    // Control packet decode; port indexes beyond the stream count never match
    always_comb begin
        ctrl_hit   = is_ctrl(bus.din_leaf_bft2interface);
        ctrl_op    = ctrl_op_e'(bus.din_leaf_bft2interface[ADDR_LSB+5 +: 2]);
        ctrl_sel   = bus.din_leaf_bft2interface[ADDR_LSB +: 4];
        credit_add = bus.din_leaf_bft2interface[CREDIT_BITS-1:0];
        cfg_wr     = '0;
        credit_wr  = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            cfg_wr[i]    = ctrl_hit && (ctrl_op == OP_CFG)    && (ctrl_sel == 4'(i));
            credit_wr[i] = ctrl_hit && (ctrl_op == OP_CREDIT) && (ctrl_sel == 4'(i));
        end
    end

    // A port may compete only when configured, holding credit, and the link is not stalled
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            eligible[i] = bus.vld_user2interface[i] && cfg_valid_q[i]
                          && (credit_q[i] != '0) && !bus.resend;
        end
    end

    rr_arbiter #(
        .N     (NUM_OUT_PORTS),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (reset),
        .req_i     (eligible),
        .advance_i (any_grant),
        .grant_o   (grant),
        .idx_o     (gnt_idx)
    );

    assign any_grant = |grant;

    // Assemble the winner's packet from registered destination and sequence state
    always_comb begin
        pkt_data = '0;
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            if (grant[i]) begin
                pkt_data = bus.din_leaf_user2interface[i*PAYLOAD_BITS +: PAYLOAD_BITS];
            end
        end
        out_pkt.valid   = 1'b1;
        out_pkt.leaf    = dest_leaf_q[gnt_idx];
        out_pkt.port    = dest_port_q[gnt_idx];
        out_pkt.addr    = seq_q[gnt_idx];
        out_pkt.payload = pkt_data;
    end

    // Next state of the per-port register files and the output link
    always_comb begin
        for (int i = 0; i < NUM_OUT_PORTS; i++) begin
            dest_leaf_d[i] = dest_leaf_q[i];
            dest_port_d[i] = dest_port_q[i];
            credit_d[i]    = credit_q[i];
            seq_d[i]       = seq_q[i];
            if (cfg_wr[i]) begin
                dest_leaf_d[i] = bus.din_leaf_bft2interface[4 +: NUM_LEAF_BITS];
                dest_port_d[i] = bus.din_leaf_bft2interface[0 +: NUM_PORT_BITS];
            end
            // Saturate the top-up first, then charge a same-cycle grant
            if (credit_wr[i]) begin
                credit_d[i] = sat_add(credit_q[i], credit_add);
            end
            if (grant[i]) begin
                credit_d[i] = credit_d[i] - CREDIT_BITS'(1);
                seq_d[i]    = seq_q[i] + NUM_ADDR_BITS'(1);
            end
        end
        cfg_valid_d = cfg_valid_q | cfg_wr;
        last_d      = any_grant ? out_pkt : last_q;
        if (bus.resend) begin
            dout_d = last_q;
        end else if (any_grant) begin
            dout_d = out_pkt;
        end else begin
            dout_d = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                dest_leaf_q[i] <= '0;
                dest_port_q[i] <= '0;
                credit_q[i]    <= CREDIT_INIT;
                seq_q[i]       <= '0;
            end
            cfg_valid_q <= '0;
            dout_q      <= '0;
            last_q      <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT_PORTS; i++) begin
                dest_leaf_q[i] <= dest_leaf_d[i];
                dest_port_q[i] <= dest_port_d[i];
                credit_q[i]    <= credit_d[i];
                seq_q[i]       <= seq_d[i];
            end
            cfg_valid_q <= cfg_valid_d;
            dout_q      <= dout_d;
            last_q      <= last_d;
        end
    end

    assign bus.dout_leaf_interface2bft = dout_q;
    assign bus.ack_interface2user      = grant;

    function automatic logic [CREDIT_BITS-1:0] sat_add(input logic [CREDIT_BITS-1:0] a,
                                                       input logic [CREDIT_BITS-1:0] b);
        logic [CREDIT_BITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[CREDIT_BITS] ? CREDIT_MAX : s[CREDIT_BITS-1:0];
    endfunction

endmodule

// File: tb/tb_leaf_out_sched.sv
// Bench for leaf_out_sched: vector table, directed corner sequences and a
// random run checked against a behavioural model of the scheduling rules.
module tb_leaf_out_sched;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    leaf_out_sched_if #(.NUM_OUT_PORTS(N)) bus ();

    leaf_out_sched #(
        .NUM_OUT_PORTS         (N),
        .CREDIT_BITS           (9),
        .FREESPACE_UPDATE_SIZE (64)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    // behavioural model
    int          m_cfg    [N];
    int          m_leaf   [N];
    int          m_port   [N];
    int          m_credit [N];
    int          m_seq    [N];
    int          m_rr;
    logic [48:0] m_last;

    logic [48:0] last_dout;
    logic [3:0]  last_ack;

    typedef struct {
        logic [3:0]  vld;
        logic [31:0] data;
        logic [48:0] bft;
        logic        rs;
        logic [3:0]  e_ack;
        logic [48:0] e_dout;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [48:0] mk(input int v, input int leaf, input int port,
                                       input int addr, input logic [31:0] pl);
        logic [48:0] p;
        p = {1'(v), 5'(leaf), 4'(port), 7'(addr), pl};
        return p;
    endfunction

    function automatic logic [48:0] ctrl(input int op, input int sel, input logic [31:0] pl);
        return mk(1, 0, 0, op * 32 + sel, pl);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cfg[i]    = 0;
            m_leaf[i]   = 0;
            m_port[i]   = 0;
            m_credit[i] = 64;
            m_seq[i]    = 0;
        end
        m_rr   = 0;
        m_last = '0;
    endtask

    function automatic int model_pick();
        int p;
        if (bus.resend) return -1;
        for (int k = 0; k < N; k++) begin
            p = (m_rr + k) % N;
            if (bus.vld_user2interface[p] && m_cfg[p] != 0 && m_credit[p] != 0) return p;
        end
        return -1;
    endfunction

    task automatic model_step(input int g, output logic [48:0] exp);
        logic [48:0] pkt;
        logic [48:0] p;
        int          sel;
        int          op;
        pkt = '0;
        if (g >= 0) pkt = mk(1, m_leaf[g], m_port[g], m_seq[g],
                             bus.din_leaf_user2interface[g*32 +: 32]);
        if (bus.resend)  exp = m_last;
        else if (g >= 0) exp = pkt;
        else             exp = '0;
        if (g >= 0) begin
            m_last   = pkt;
            m_seq[g] = (m_seq[g] + 1) % 128;
            m_rr     = (g + 1) % N;
        end
        p = bus.din_leaf_bft2interface;
        if (p[48] && p[42:39] == 4'd0) begin
            sel = int'(p[35:32]);
            op  = int'(p[38:37]);
            if (sel < N) begin
                if (op == 1) begin
                    m_leaf[sel] = int'(p[8:4]);
                    m_port[sel] = int'(p[3:0]);
                    m_cfg[sel]  = 1;
                end else if (op == 2) begin
                    m_credit[sel] = m_credit[sel] + int'(p[8:0]);
                    if (m_credit[sel] > 511) m_credit[sel] = 511;
                end
            end
        end
        if (g >= 0) m_credit[g] = m_credit[g] - 1;
    endtask

    // One clock: drive, check ack mid-cycle, check dout just after the edge
    task automatic run_cycle(input logic [3:0] vld, input logic [127:0] data,
                             input logic [48:0] bft, input logic rs);
        int          g;
        logic [48:0] exp;
        bus.vld_user2interface      = vld;
        bus.din_leaf_user2interface = data;
        bus.din_leaf_bft2interface  = bft;
        bus.resend                  = rs;
        @(negedge clk);
        g = model_pick();
        last_ack = bus.ack_interface2user;
        check("ack", 64'(last_ack), (g >= 0) ? (64'd1 << g) : 64'd0);
        @(posedge clk);
        #1;
        model_step(g, exp);
        last_dout = bus.dout_leaf_interface2bft;
        check("dout", 64'(last_dout), 64'(exp));
    endtask

    task automatic idle_inputs();
        bus.vld_user2interface      = '0;
        bus.din_leaf_user2interface = '0;
        bus.din_leaf_bft2interface  = '0;
        bus.resend                  = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("rst_ack", 64'(bus.ack_interface2user), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, run incomplete");
        $fatal(1, "watchdog");
    end

    initial begin
        int          acks;
        int          ack3;
        logic [48:0] p_hold;
        logic [48:0] bft;
        int          r;

        tbl[0]  = '{4'b0000, 32'h0,        ctrl(1, 1, 32'h53),                    1'b0, 4'b0000, 49'd0};
        tbl[1]  = '{4'b0010, 32'hDEADBEEF, 49'd0,                                 1'b0, 4'b0010, mk(1, 5, 3, 0, 32'hDEADBEEF)};
        tbl[2]  = '{4'b0000, 32'h0,        49'd0,                                 1'b0, 4'b0000, 49'd0};
        tbl[3]  = '{4'b0001, 32'h12345678, 49'd0,                                 1'b0, 4'b0000, 49'd0};
        tbl[4]  = '{4'b0000, 32'h0,        ctrl(1, 9, 32'h53),                    1'b0, 4'b0000, 49'd0};
        tbl[5]  = '{4'b0010, 32'h11111111, 49'd0,                                 1'b0, 4'b0010, mk(1, 5, 3, 1, 32'h11111111)};
        tbl[6]  = '{4'b0010, 32'h22222222, ctrl(3, 1, 32'h7F),                    1'b0, 4'b0010, mk(1, 5, 3, 2, 32'h22222222)};
        tbl[7]  = '{4'b0010, 32'hAAAAAAAA, 49'd0,                                 1'b1, 4'b0000, mk(1, 5, 3, 2, 32'h22222222)};
        tbl[8]  = '{4'b0010, 32'h33333333, ctrl(1, 1, 32'h96),                    1'b0, 4'b0010, mk(1, 5, 3, 3, 32'h33333333)};
        tbl[9]  = '{4'b0010, 32'h44444444, 49'd0,                                 1'b0, 4'b0010, mk(1, 9, 6, 4, 32'h44444444)};
        tbl[10] = '{4'b0000, 32'h0,        mk(1, 0, 2, 32, 32'h77),               1'b0, 4'b0000, 49'd0};
        tbl[11] = '{4'b0000, 32'h0,        mk(0, 0, 0, 32, 32'h77),               1'b0, 4'b0000, 49'd0};
        tbl[12] = '{4'b0001, 32'h55555555, 49'd0,                                 1'b0, 4'b0000, 49'd0};

        idle_inputs();
        do_reset();

        // vector table
        for (int i = 0; i < 13; i++) begin
            run_cycle(tbl[i].vld, {4{tbl[i].data}}, tbl[i].bft, tbl[i].rs);
            check($sformatf("tbl%0d_ack", i), 64'(last_ack), 64'(tbl[i].e_ack));
            check($sformatf("tbl%0d_dout", i), 64'(last_dout), 64'(tbl[i].e_dout));
        end

        // round robin across all four ports, then resend hold and release
        do_reset();
        for (int i = 0; i < N; i++) run_cycle(4'b0000, '0, ctrl(1, i, 32'((10 + i) * 16 + i + 1)), 1'b0);
        for (int k = 0; k < 8; k++) begin
            run_cycle(4'b1111, rnd_data(), '0, 1'b0);
            check("rr_ack", 64'(last_ack), 64'd1 << (k % 4));
            check("rr_addr", 64'(last_dout[38:32]), 64'(k / 4));
        end
        p_hold = last_dout;
        for (int k = 0; k < 3; k++) begin
            run_cycle(4'b1111, rnd_data(), '0, 1'b1);
            check("resend_dout", 64'(last_dout), 64'(p_hold));
            check("resend_ack", 64'(last_ack), 64'd0);
        end
        run_cycle(4'b1111, rnd_data(), '0, 1'b0);
        check("resend_resume", 64'(last_ack), 64'b0001);

        // asynchronous reset in the middle of traffic
        bus.vld_user2interface = 4'b1111;
        #2;
        reset = 1'b0;
        #1;
        check("async_rst_dout", 64'(bus.dout_leaf_interface2bft), 64'd0);
        check("async_rst_ack", 64'(bus.ack_interface2user), 64'd0);
        #3;
        idle_inputs();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // drain port 0's credit, then top it up by 2
        run_cycle(4'b0000, '0, ctrl(1, 0, 32'h12), 1'b0);
        acks = 0;
        for (int k = 0; k < 70; k++) begin
            run_cycle(4'b0001, rnd_data(), '0, 1'b0);
            acks += int'(last_ack[0]);
        end
        check("drain_cnt", 64'(acks), 64'd64);
        check("drain_stall_ack", 64'(last_ack), 64'd0);
        check("drain_stall_valid", 64'(last_dout[48]), 64'd0);
        acks = 0;
        run_cycle(4'b0001, rnd_data(), ctrl(2, 0, 32'd2), 1'b0);
        acks += int'(last_ack[0]);
        for (int k = 0; k < 4; k++) begin
            run_cycle(4'b0001, rnd_data(), '0, 1'b0);
            acks += int'(last_ack[0]);
        end
        check("topup2_cnt", 64'(acks), 64'd2);

        // credit update landing on the same cycle as a grant with credit 1
        run_cycle(4'b0000, '0, ctrl(2, 0, 32'd1), 1'b0);
        run_cycle(4'b0001, rnd_data(), ctrl(2, 0, 32'd5), 1'b0);
        check("same_cycle_grant", 64'(last_ack), 64'b0001);
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            run_cycle(4'b0001, rnd_data(), '0, 1'b0);
            acks += int'(last_ack[0]);
        end
        check("same_cycle_credit", 64'(acks), 64'd5);

        // sequence wrap on port 2; port 3 stays unconfigured
        do_reset();
        run_cycle(4'b0000, '0, ctrl(1, 2, 32'h47), 1'b0);
        run_cycle(4'b0000, '0, ctrl(2, 2, 32'd200), 1'b0);
        ack3 = 0;
        for (int k = 0; k < 130; k++) begin
            run_cycle(4'b1100, rnd_data(), '0, 1'b0);
            ack3 += int'(last_ack[3]);
            check("wrap_addr", 64'(last_dout[38:32]), 64'(k % 128));
        end
        check("unconfigured_never_acked", 64'(ack3), 64'd0);

        // random traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 9));
            if (r < 2)       bft = ctrl(1, int'($urandom_range(0, 5)), 32'($urandom));
            else if (r < 4)  bft = ctrl(2, int'($urandom_range(0, 5)),
                                        ($urandom_range(0, 15) == 0) ? 32'd511 : 32'($urandom_range(0, 6)));
            else if (r == 4) bft = mk(int'($urandom_range(0, 1)), int'($urandom), int'($urandom),
                                      int'($urandom), 32'($urandom));
            else             bft = '0;
            run_cycle(4'($urandom), rnd_data(), bft, ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/leaf_out_sched.md
Name: leaf_out_sched

Overview:
- Output-side scheduler for a leaf: shares the single 49-bit BFT output link between NUM_OUT_PORTS user output streams.
- Per-port destination registers are written by config packets arriving on the BFT input. Per-port credit counters are replenished by credit-update packets.
- Arbitration is round-robin among eligible ports. Each winner's 32-bit word is wrapped into a packet and driven to the BFT.

Parameters:
- PACKET_BITS, 49, total packet width
- PAYLOAD_BITS, 32, user data width
- NUM_LEAF_BITS, 5, destination leaf field width
- NUM_PORT_BITS, 4, destination port field width
- NUM_ADDR_BITS, 7, address/sequence field width
- NUM_OUT_PORTS, 4, user output streams (1..15)
- CREDIT_BITS, 9, credit counter width
- FREESPACE_UPDATE_SIZE, 64, credit value loaded at reset (0 disables initial credit)

Ports:
- clk  in  1  single clock
- reset  in  1  asynchronous, active-low reset
- din_leaf_bft2interface  in  PACKET_BITS  incoming BFT packet
- dout_leaf_interface2bft  out  PACKET_BITS  outgoing BFT packet
- resend  in  1  retransmit/stall request from BFT
- din_leaf_user2interface  in  NUM_OUT_PORTS*PAYLOAD_BITS  user data, port i at slice i
- vld_user2interface  in  NUM_OUT_PORTS  user data valid
- ack_interface2user  out  NUM_OUT_PORTS  one-cycle accept pulse

Behaviour:
- Packet format: [48] valid, [47:43] leaf, [42:39] port, [38:32] addr, [31:0] payload.
- Reset (async assert, sync deassert use) clears the following:
  - dout = 0, ack = 0, rr pointer = 0.
  - All cfg_valid = 0, dest regs = 0.
  - Credits = FREESPACE_UPDATE_SIZE, seq counters = 0.
- Control packets are incoming packets with valid=1 and port==0. They are decoded every cycle and ignored otherwise. Port selected = addr[3:0]; indexes >= NUM_OUT_PORTS are ignored.
  - addr[6:5]=01 (config): dest_leaf[sel] = payload[8:4], dest_port[sel] = payload[3:0], cfg_valid[sel] = 1.
  - addr[6:5]=10 (credit): credit[sel] += payload[CREDIT_BITS-1:0], saturating at 2^CREDIT_BITS-1.
  - addr[6:5]=00 or 11: ignored.
- Eligibility of port i: vld[i] & cfg_valid[i] & credit[i] != 0 & !resend.
- Arbitration: round-robin, searching from rr pointer upward with wrap. At most one grant per cycle.
- On grant of port g:
  - ack[g] = 1 in the same cycle (combinational from registered state plus vld). The user may drop vld or change data the following cycle.
  - Next cycle dout = {1, dest_leaf[g], dest_port[g], seq[g], data[g]}. Latency is 1 cycle from grant to packet.
  - seq[g] increments, wrapping 127 -> 0.
  - credit[g] decrements.
  - rr pointer = g+1, wrapping to 0 after NUM_OUT_PORTS-1.
- No grant: dout valid bit = 0 next cycle and other fields = 0. The rr pointer holds.
- resend = 1:
  - No grants and all ack = 0.
  - dout re-drives the last emitted valid packet each cycle resend is held. If no packet has been emitted since reset, dout = 0.
  - After resend drops, normal arbitration resumes the same cycle.
- Credit update and grant on the same port in the same cycle: new = sat(old + add) - 1; sat applies before the decrement.
- Config write and grant on the same port in the same cycle: the packet uses the old dest; the new dest applies from the next cycle.
- Credit at 0: the port is not eligible; vld stays pending with no ack. The user must hold vld/data until ack.
- Reset asserted mid-packet: dout clears immediately (async). Any in-flight word is lost; the user sees no ack.

Decomposition:
- Shared package leaf_pkg holds:
  - packet field offsets/widths (VALID_BIT, LEAF_LSB, PORT_LSB, ADDR_LSB);
  - control opcodes (OP_CFG=2'b01, OP_CREDIT=2'b10);
  - control port id 0.
- One sub-module, rr_arbiter: parameterised N-way round-robin. Inputs: req, advance. Outputs: one-hot grant, index. The pointer lives inside it.
- Credit/config/seq register files stay in leaf_out_sched.

Test Plan:
1. Reset, then config port 1 (leaf 5, port 3), vld[1]=1 data 0xDEADBEEF.
   -> ack[1] pulse; next cycle dout = {1, 5'd5, 4'd3, 7'd0, 32'hDEADBEEF}; credit[1] = 63.
2. All 4 ports configured and valid continuously for 8 cycles.
   -> grant order 0,1,2,3,0,1,2,3; each port's addr field goes 0 then 1.
3. Port 0 credit drained: 64 grants, then vld held.
   -> no ack, dout valid = 0. Credit packet (payload 2) -> exactly 2 more packets, then stall.
4. Credit update +5 in the same cycle as a grant on a port with credit 1.
   -> credit becomes 5.
5. resend held 3 cycles after a packet P.
   -> dout = P for 3 cycles, ack = 0. After release, the next eligible port per rr pointer is granted.
6. 128 grants on one port with credits topped up.
   -> addr field wraps 127 -> 0. Unconfigured port with vld=1 is never acked.
